// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths and the writeback request record.
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr, ptr moves past the winner on advance.
// Zero-cycle grant; grant depends only on req and ptr, so a granted requester transfers the same cycle.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] NV = (PW+1)'(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] off;
  logic [PW-1:0] gidx;
  logic [N-1:0]  rot;
  logic          hit;
  logic [PW:0]   sum;
  logic [PW:0]   nxt;

  always_comb begin
    // Rotate so bit 0 is the requester at ptr; lowest set bit is the winner.
    rot = N'({req, req} >> ptr);
    off = '0;
    hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = PW'(k);
        hit = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    gidx  = sum[PW-1:0];
    grant = hit ? (N'(1) << gidx) : '0;
    nxt   = {1'b0, gidx} + (PW+1)'(1);
    if (nxt == NV) nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && hit) begin
      ptr <= nxt[PW-1:0];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among NUM_REQ writeback sources; registered write one cycle after transfer.
// Accepts one write every cycle (no backpressure from the port); busy bitmap tracks reserved destinations.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wb_we,
  output logic [ADDR_W-1:0]           wb_waddr,
  output logic [DATA_W-1:0]           wb_wdata,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_addr,
  output logic [(1<<ADDR_W)-1:0]      busy
);

  localparam int NREG = 1 << ADDR_W;

  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_nxt;

  // Some requester always wins when any is valid, so any valid means a transfer.
  assign xfer = |req_valid;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .grant   (req_ready)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      wb_we <= xfer && (sel_addr != '0);
      if (xfer) begin
        wb_waddr <= sel_addr;
        wb_wdata <= sel_data;
      end
    end
  end

  // Reservation is applied after the clear so a same-cycle re-issue stays pending.
  always_comb begin
    busy_nxt = busy;
    if (wb_we) busy_nxt[wb_waddr] = 1'b0;
    if (issue_valid && (issue_addr != '0)) busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a cycle-level reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_we;
  logic [3:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic [15:0] busy;

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  int          mptr;
  bit          m_we;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [15:0] m_busy;
  int          last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_grant(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mptr    = 0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_busy  = '0;
    last_g  = -1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [3:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_addr[i*4 +: 4] = a;
    req_data[i*32 +: 32] = d;
  endtask

  // One clock cycle: check at negedge, advance the model at posedge, return 1 time unit later.
  task automatic tick(input int exp_rdy);
    int g;
    logic [15:0] nb;
    @(negedge clk);
    g = model_grant(req_valid, mptr);
    chk("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (exp_rdy >= 0) chk("req_ready_seq", 64'(req_ready), 64'(exp_rdy));
    chk("wb_we", 64'(wb_we), 64'(m_we));
    chk("wb_waddr", 64'(wb_waddr), 64'(m_waddr));
    chk("wb_wdata", 64'(wb_wdata), 64'(m_wdata));
    chk("busy", 64'(busy), 64'(m_busy));
    @(posedge clk);
    nb = m_busy;
    if (m_we) nb[m_waddr] = 1'b0;
    if (issue_valid && issue_addr != 4'd0) nb[issue_addr] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    if (g >= 0) begin
      m_waddr = req_addr[g*4 +: 4];
      m_wdata = req_data[g*32 +: 32];
      m_we    = (m_waddr != 4'd0);
      mptr    = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  initial begin
    // 1. Reset with all requesters valid
    rst = 1'b1;
    req_valid = 3'b000; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
    set_req(0, 1'b1, 4'd1, 32'h1111_0000);
    set_req(1, 1'b1, 4'd2, 32'h2222_0000);
    set_req(2, 1'b1, 4'd3, 32'h3333_0000);
    model_reset();
    #1;
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_waddr", 64'(wb_waddr), 64'd0);
    chk("rst_wdata", 64'(wb_wdata), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'b001);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 3. Round-robin with all valid for six cycles
    for (int k = 0; k < 6; k++) begin
      tick(1 << (k % 3));
      set_req(0, 1'b1, 4'd1, 32'h1111_0000 + k);
      set_req(1, 1'b1, 4'd2, 32'h2222_0000 + k);
      set_req(2, 1'b1, 4'd3, 32'h3333_0000 + k);
    end
    req_valid = 3'b000;

    // 2. Single request
    set_req(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
    tick(3'b001);
    req_valid = 3'b000;
    chk("single_we", 64'(wb_we), 64'd1);
    chk("single_waddr", 64'(wb_waddr), 64'd5);
    chk("single_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
    tick(-1);

    // 4. Write to r0 is accepted but dropped
    set_req(1, 1'b1, 4'd0, 32'h0000_1234);
    tick(3'b010);
    req_valid = 3'b000;
    chk("r0_we", 64'(wb_we), 64'd0);
    chk("r0_busy0", 64'(busy[0]), 64'd0);
    tick(-1);

    // 5. Scoreboard set / clear / set-wins
    issue_valid = 1'b1; issue_addr = 4'd7;
    tick(-1);
    issue_valid = 1'b0;
    chk("sb_set7", 64'(busy[7]), 64'd1);
    set_req(2, 1'b1, 4'd7, 32'h7777_7777);
    tick(3'b100);
    req_valid = 3'b000;
    chk("sb_we7", 64'(wb_we), 64'd1);
    chk("sb_still7", 64'(busy[7]), 64'd1);
    tick(-1);
    chk("sb_clr7", 64'(busy[7]), 64'd0);
    issue_valid = 1'b1; issue_addr = 4'd7;
    tick(-1);
    issue_valid = 1'b0;
    set_req(2, 1'b1, 4'd7, 32'h7777_0001);
    tick(-1);
    req_valid = 3'b000;
    issue_valid = 1'b1; issue_addr = 4'd7;
    tick(-1);
    issue_valid = 1'b0;
    chk("sb_setwins7", 64'(busy[7]), 64'd1);

    // 6. Reset right after a grant, before the write is seen
    issue_valid = 1'b1; issue_addr = 4'd9;
    set_req(0, 1'b1, 4'd9, 32'h9999_9999);
    tick(-1);
    issue_valid = 1'b0;
    req_valid = 3'b000;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 64'(wb_we), 64'd0);
    chk("mid_rst_waddr", 64'(wb_waddr), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 3'b111;
    tick(3'b001);
    req_valid = 3'b000;
    tick(-1);

    // Randomized traffic; a valid request is held until it is granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || last_g == i) begin
          set_req(i, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom);
        end
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = 4'($urandom_range(0, 15));
      tick(-1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
